// File: rtl/mem_stage.sv
// Memory-access stage with MEM/WB pipeline register: word loads/stores on an internal
// RAM with MEM_LATENCY-cycle accesses, upstream stall generation and branch/jump PC select.
module mem_stage #(
    parameter int ADDR_BITS   = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  writebackreg_exmem,
    input  logic [31:0] alu_result_exmem,
    input  logic [31:0] signextend_exmem,
    input  logic [31:0] rt_data_exmem,
    input  logic        mem_read_exmem,
    input  logic        mem_write_exmem,
    input  logic        mem_to_reg_exmem,
    input  logic        reg_write_exmem,
    input  logic        jump_exmem,
    input  logic        branch_exmem,
    input  logic        zero_exmem,
    output logic        mem_stall,
    output logic        pcsrc_mem,
    output logic        jump_mem,
    output logic        mem_fault,
    output logic [31:0] read_data_memwb,
    output logic [31:0] alu_result_memwb,
    output logic [31:0] signextend_memwb,
    output logic [4:0]  writebackreg_memwb,
    output logic        reg_write_memwb,
    output logic        mem_to_reg_memwb
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT     = 1'b1;
    localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);
    localparam int         DEPTH    = 1 << ADDR_BITS;

    logic [31:0] ram [DEPTH];

    logic [0:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 mem_op, misaligned, access, load_hit;
    logic                 stall_raw, capture, ram_we;
    logic [ADDR_BITS-1:0] ram_idx;

    logic [31:0] read_data_q, read_data_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] signextend_q, signextend_d;
    logic [4:0]  writebackreg_q, writebackreg_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic        mem_fault_q, mem_fault_d;

    assign mem_op     = mem_read_exmem | mem_write_exmem;
    assign misaligned = mem_op & (alu_result_exmem[1:0] != 2'b00);
    assign access     = mem_op & ~misaligned;
    assign load_hit   = access & mem_read_exmem & ~mem_write_exmem;
    assign ram_idx    = alu_result_exmem[ADDR_BITS+1:2];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && (MEM_LATENCY > 1)) begin
                    stall_raw = 1'b1;
                    cnt_d     = 4'd1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q < LAST_CNT) begin
                    stall_raw = 1'b1;
                    cnt_d     = cnt_q + 4'd1;
                end else begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
        endcase
    end

    // Reset masks the stall at once and blocks any RAM write, aborting an access in flight.
    assign mem_stall = stall_raw & ~rst;
    assign capture   = ~stall_raw;
    assign ram_we    = capture & access & mem_write_exmem & ~rst;
    assign pcsrc_mem = branch_exmem & zero_exmem;
    assign jump_mem  = jump_exmem;

    always_comb begin
        read_data_d    = read_data_q;
        alu_result_d   = alu_result_q;
        signextend_d   = signextend_q;
        writebackreg_d = writebackreg_q;
        reg_write_d    = 1'b0;
        mem_to_reg_d   = 1'b0;
        mem_fault_d    = 1'b0;
        if (capture) begin
            read_data_d    = load_hit ? ram[ram_idx] : 32'd0;
            alu_result_d   = alu_result_exmem;
            signextend_d   = signextend_exmem;
            writebackreg_d = writebackreg_exmem;
            reg_write_d    = reg_write_exmem & ~misaligned;
            mem_to_reg_d   = mem_to_reg_exmem;
            mem_fault_d    = misaligned;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= rt_data_exmem;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            read_data_q    <= 32'd0;
            alu_result_q   <= 32'd0;
            signextend_q   <= 32'd0;
            writebackreg_q <= 5'd0;
            reg_write_q    <= 1'b0;
            mem_to_reg_q   <= 1'b0;
            mem_fault_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            read_data_q    <= read_data_d;
            alu_result_q   <= alu_result_d;
            signextend_q   <= signextend_d;
            writebackreg_q <= writebackreg_d;
            reg_write_q    <= reg_write_d;
            mem_to_reg_q   <= mem_to_reg_d;
            mem_fault_q    <= mem_fault_d;
        end
    end

    assign read_data_memwb    = read_data_q;
    assign alu_result_memwb   = alu_result_q;
    assign signextend_memwb   = signextend_q;
    assign writebackreg_memwb = writebackreg_q;
    assign reg_write_memwb    = reg_write_q;
    assign mem_to_reg_memwb   = mem_to_reg_q;
    assign mem_fault          = mem_fault_q;

endmodule
